// File: rtl/warp_pc_scheduler.sv
// warp_pc_scheduler: per-warp program counters with a round-robin fetch arbiter
//   clk_i            rising-edge clock
//   reset_i          asynchronous active-high reset
//   start_i          launch kernel (honoured in IDLE/DONE only)
//   start_pc_i       initial PC for every warp
//   warp_mask_i      warps enabled by start
//   stall_i          per-warp scoreboard hold
//   fetch_valid_o    a warp presents a fetch address
//   fetch_warp_o     granted warp id
//   fetch_addr_o     PC of the granted warp
//   fetch_ready_i    front end accepts the fetch
//   branch_valid_i   load branch_target_i into warp branch_warp_i
//   branch_warp_i    branch target warp
//   branch_target_i  new PC
//   halt_valid_i     retire warp halt_warp_i
//   halt_warp_i      warp to retire
//   busy_o           kernel running
//   done_o           kernel finished
module warp_pc_scheduler #(
    parameter int NUM_WARPS = 4,
    parameter int WARP_W    = 2,
    parameter int ADDR_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    start_pc_i,
    input  logic [NUM_WARPS-1:0] warp_mask_i,
    input  logic [NUM_WARPS-1:0] stall_i,
    output logic                 fetch_valid_o,
    output logic [WARP_W-1:0]    fetch_warp_o,
    output logic [ADDR_W-1:0]    fetch_addr_o,
    input  logic                 fetch_ready_i,
    input  logic                 branch_valid_i,
    input  logic [WARP_W-1:0]    branch_warp_i,
    input  logic [ADDR_W-1:0]    branch_target_i,
    input  logic                 halt_valid_i,
    input  logic [WARP_W-1:0]    halt_warp_i,
    output logic                 busy_o,
    output logic                 done_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                 state_q;
    logic [ADDR_W-1:0]      pc_q [NUM_WARPS];
    logic [NUM_WARPS-1:0]   active_q;
    logic [WARP_W-1:0]      last_grant_q;
    logic                   busy_q;
    logic                   done_q;
    logic [NUM_WARPS-1:0]   eligible;
    logic [WARP_W-1:0]      grant;
    logic [WARP_W-1:0]      idx;
    logic                   found;
    logic                   xfer;
    assign eligible = {NUM_WARPS{state_q == RUN}} & active_q & ~stall_i;
    // Search upward from the warp after the last transfer; the final offset
    // wraps back onto last_grant_q itself so a lone eligible warp still wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            idx = last_grant_q + WARP_W'(k);
            if (!found && eligible[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end
    assign fetch_valid_o = found;
    assign fetch_warp_o  = found ? grant : '0;
    assign fetch_addr_o  = found ? pc_q[grant] : '0;
    assign xfer          = found & fetch_ready_i;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            active_q     <= '0;
            last_grant_q <= WARP_W'(NUM_WARPS - 1);
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NUM_WARPS; i++) pc_q[i] <= '0;
        end else if (state_q == RUN) begin
            // A branch to the warp being fetched overrides its increment.
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (branch_valid_i && branch_warp_i == WARP_W'(i))
                    pc_q[i] <= branch_target_i;
                else if (xfer && grant == WARP_W'(i))
                    pc_q[i] <= pc_q[i] + ADDR_W'(1);
            end
            if (xfer) last_grant_q <= grant;
            if (halt_valid_i) active_q[halt_warp_i] <= 1'b0;
            if (active_q == '0) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end else if (start_i) begin
            for (int i = 0; i < NUM_WARPS; i++) pc_q[i] <= start_pc_i;
            active_q     <= warp_mask_i;
            last_grant_q <= WARP_W'(NUM_WARPS - 1);
            state_q      <= (|warp_mask_i) ? RUN : DONE;
            busy_q       <= |warp_mask_i;
            done_q       <= ~|warp_mask_i;
        end
    end
endmodule

// File: tb/tb_warp_pc_scheduler.sv
// tb_warp_pc_scheduler: directed checks of warp_pc_scheduler
module tb_warp_pc_scheduler;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] start_pc_i = '0;
    logic [3:0]  warp_mask_i = '0;
    logic [3:0]  stall_i = '0;
    logic        fetch_valid_o;
    logic [1:0]  fetch_warp_o;
    logic [15:0] fetch_addr_o;
    logic        fetch_ready_i = 1'b0;
    logic        branch_valid_i = 1'b0;
    logic [1:0]  branch_warp_i = '0;
    logic [15:0] branch_target_i = '0;
    logic        halt_valid_i = 1'b0;
    logic [1:0]  halt_warp_i = '0;
    logic        busy_o;
    logic        done_o;
    int vectors = 0;
    int miscompares = 0;

    warp_pc_scheduler #(.NUM_WARPS(4), .WARP_W(2), .ADDR_W(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .start_pc_i(start_pc_i),
        .warp_mask_i(warp_mask_i), .stall_i(stall_i), .fetch_valid_o(fetch_valid_o),
        .fetch_warp_o(fetch_warp_o), .fetch_addr_o(fetch_addr_o), .fetch_ready_i(fetch_ready_i),
        .branch_valid_i(branch_valid_i), .branch_warp_i(branch_warp_i),
        .branch_target_i(branch_target_i), .halt_valid_i(halt_valid_i),
        .halt_warp_i(halt_warp_i), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Check the fetch port mid-cycle, then advance past the next edge.
    task automatic cyc(input string tag, input logic v, input logic [1:0] w, input logic [15:0] a);
        @(negedge clk_i);
        chk({tag, "_valid"}, 32'(fetch_valid_o), 32'(v));
        chk({tag, "_warp"}, 32'(fetch_warp_o), 32'(w));
        chk({tag, "_addr"}, 32'(fetch_addr_o), 32'(a));
        tick();
    endtask

    initial begin
        #2;
        chk("rst_valid", 32'(fetch_valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        tick();
        tick();
        reset_i = 1'b0;
        // round robin from start
        start_i = 1'b1; start_pc_i = 16'h0010; warp_mask_i = 4'hF; fetch_ready_i = 1'b1;
        cyc("idle", 0, 0, 16'h0000);
        start_i = 1'b0;
        chk("run_busy", 32'(busy_o), 1);
        chk("run_done", 32'(done_o), 0);
        cyc("rr0", 1, 0, 16'h0010);
        cyc("rr1", 1, 1, 16'h0010);
        cyc("rr2", 1, 2, 16'h0010);
        cyc("rr3", 1, 3, 16'h0010);
        cyc("rr4", 1, 0, 16'h0011);
        // stall warp 1
        stall_i = 4'b0010;
        cyc("st0", 1, 2, 16'h0011);
        cyc("st1", 1, 3, 16'h0011);
        cyc("st2", 1, 0, 16'h0012);
        stall_i = 4'b0000;
        cyc("st3", 1, 1, 16'h0011);
        // backpressure
        fetch_ready_i = 1'b0;
        cyc("bp0", 1, 2, 16'h0012);
        cyc("bp1", 1, 2, 16'h0012);
        cyc("bp2", 1, 2, 16'h0012);
        fetch_ready_i = 1'b1;
        cyc("bp3", 1, 2, 16'h0012);
        cyc("bp4", 1, 3, 16'h0012);
        chk("bp_pc2", 32'(dut.pc_q[2]), 32'h0013);
        // branch wins over increment
        cyc("br0", 1, 0, 16'h0013);
        cyc("br1", 1, 1, 16'h0012);
        branch_valid_i = 1'b1; branch_warp_i = 2'd2; branch_target_i = 16'h0040;
        cyc("br2", 1, 2, 16'h0013);
        branch_valid_i = 1'b0;
        cyc("br3", 1, 3, 16'h0013);
        cyc("br4", 1, 0, 16'h0014);
        cyc("br5", 1, 1, 16'h0013);
        cyc("br6", 1, 2, 16'h0040);
        // PC wrap
        fetch_ready_i = 1'b0;
        branch_valid_i = 1'b1; branch_warp_i = 2'd3; branch_target_i = 16'hFFFF;
        cyc("wr0", 1, 3, 16'h0014);
        branch_valid_i = 1'b0; fetch_ready_i = 1'b1;
        cyc("wr1", 1, 3, 16'hFFFF);
        cyc("wr2", 1, 0, 16'h0015);
        cyc("wr3", 1, 1, 16'h0014);
        cyc("wr4", 1, 2, 16'h0041);
        cyc("wr5", 1, 3, 16'h0000);
        // halt every warp in its own transfer cycle
        halt_valid_i = 1'b1; halt_warp_i = 2'd0;
        cyc("h0", 1, 0, 16'h0016);
        chk("h0_pc0", 32'(dut.pc_q[0]), 32'h0017);
        halt_warp_i = 2'd1;
        cyc("h1", 1, 1, 16'h0015);
        halt_warp_i = 2'd2;
        cyc("h2", 1, 2, 16'h0042);
        halt_warp_i = 2'd3;
        cyc("h3", 1, 3, 16'h0001);
        halt_valid_i = 1'b0;
        chk("h_busy_still", 32'(busy_o), 1);
        cyc("drain", 0, 0, 16'h0000);
        chk("fin_busy", 32'(busy_o), 0);
        chk("fin_done", 32'(done_o), 1);
        // restart from DONE; start during RUN is ignored
        start_i = 1'b1; start_pc_i = 16'h0100; warp_mask_i = 4'b0101;
        tick();
        chk("re_busy", 32'(busy_o), 1);
        chk("re_done", 32'(done_o), 0);
        start_pc_i = 16'h0200; warp_mask_i = 4'hF;
        cyc("ign0", 1, 0, 16'h0100);
        start_i = 1'b0;
        cyc("ign1", 1, 2, 16'h0100);
        // asynchronous reset mid-cycle
        #3 reset_i = 1'b1;
        #1;
        chk("ar_valid", 32'(fetch_valid_o), 0);
        chk("ar_busy", 32'(busy_o), 0);
        chk("ar_done", 32'(done_o), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("ar_pc%0d", i), 32'(dut.pc_q[i]), 0);
        tick();
        reset_i = 1'b0;
        // empty mask goes straight to DONE
        start_i = 1'b1; warp_mask_i = 4'b0000;
        tick();
        start_i = 1'b0;
        chk("m0_busy", 32'(busy_o), 0);
        chk("m0_done", 32'(done_o), 1);
        cyc("m0", 0, 0, 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
